hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have: i_clock  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: i_reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: i_id_valid  in  1  ID holds a real instruction.
REQ-004 SHALL have: i_id_rs1, i_id_rs2, i_id_rd  in  5 each  ID register addresses.
REQ-005 SHALL have: i_id_reg_write, i_id_mem_read  in  1 each  ID writes rd / ID is a load.
REQ-006 SHALL have: i_flush  in  1  taken branch/jump resolved in EX, kill ID.
REQ-007 SHALL have: o_forward_rs1, o_forward_rs2  out  2 each  EX operand select: 2'b10 EX/MEM result, 2'b01 WB result, 2'b00 regfile.
REQ-008 SHALL have: o_stall  out  1  hold PC and IF/ID, bubble into EX.
REQ-009 SHALL have: o_stall_count  out  NB_WORD  saturating count of stall cycles.

Function
REQ-010 SHALL keep three tracking entries (ID/EX, EX/MEM, MEM/WB), each {valid, rs1, rs2, rd, reg_write, mem_read}, advancing one stage per clock.
REQ-011 ID/EX SHALL load ID fields when i_id_valid=1, o_stall=0, i_flush=0; otherwise it SHALL load a bubble (valid=0).
REQ-012 EX/MEM SHALL take ID/EX and MEM/WB SHALL take EX/MEM every clock unconditionally.
REQ-013 o_forward_rsN SHALL be combinational from registered entries only: 2'b10 if EX/MEM valid, reg_write, rd!=0, rd==ID/EX rsN; else 2'b01 if the same holds for MEM/WB; else 2'b00.
REQ-014 EX/MEM SHALL win over MEM/WB when both match (youngest producer).
REQ-015 x0 SHALL never be forwarded or cause a stall.
REQ-016 o_stall SHALL be 1 when i_id_valid, ID/EX valid, mem_read, rd!=0 and rd equals i_id_rs1 or i_id_rs2 (load-use), lasting exactly one cycle per load.
REQ-017 i_flush SHALL take priority over o_stall: o_stall forced 0 that cycle, ID/EX loads a bubble.
REQ-018 o_stall_count SHALL increment by 1 on each clock where o_stall=1 and hold at all-ones.
REQ-019 Forwarding latency SHALL be zero cycles (same cycle as the consuming instruction sits in EX).

Reset
REQ-020 While i_reset=0, all entry valid bits, o_stall_count SHALL clear asynchronously; outputs SHALL be o_forward_rs1=o_forward_rs2=2'b00, o_stall=0.
REQ-021 Reset asserted mid-stall SHALL drop o_stall immediately; the first post-reset ID instruction SHALL enter ID/EX without stall.

Configuration
REQ-022 Macro HAZARD_FORWARDING_EN SHALL select the hazard policy.
REQ-023 Defined: behaviour per REQ-013..REQ-017.
REQ-024 Undefined: o_forward_rs1/rs2 tied to 2'b00; o_stall=1 whenever an ID source (rd!=0) matches rd of any valid reg_write entry in ID/EX or EX/MEM (regfile writes first half, so MEM/WB needs no stall); flush priority unchanged.

Structure
REQ-025 riscv_defs SHALL hold NB_REG_ADDR=5, forward_sel_t enum (FWD_REGFILE=2'b00, FWD_WB=2'b01, FWD_EX_MEM=2'b10) and hazard_entry_t struct.
REQ-026 SHALL instantiate sub-module fwd_select twice (one per source operand), doing the REQ-013/014 comparison.

Verification
REQ-027 add x5 then add x6,x5,x1 back-to-back -> o_forward_rs1=2'b10 while second in EX, o_stall=0.
REQ-028 add x5; nop; sub x7,x1,x5 -> o_forward_rs2=2'b01 for sub.
REQ-029 lw x5 then add x6,x5,x5 -> o_stall=1 for one cycle, bubble in EX, then o_forward_rs1=o_forward_rs2=2'b01; o_stall_count=1.
REQ-030 lw x0 then add x6,x0,x0 -> no stall, forwards 2'b00.
REQ-031 load-use coincident with i_flush=1 -> o_stall=0, ID/EX bubble, o_stall_count unchanged.
REQ-032 reset pulsed during stall cycle, then add x6,x5,x1 -> o_stall=0, all forwards 2'b00.

Source files
------------

// File: rtl/riscv_defs.sv
// Shared register-address, forwarding-select and pipeline-tracking types for the hazard unit.
package riscv_defs;

  localparam int unsigned NB_REG_ADDR = 5;

  typedef logic [NB_REG_ADDR-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_WB      = 2'b01,
    FWD_EX_MEM  = 2'b10
  } forward_sel_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      reg_write;
    logic      mem_read;
  } hazard_entry_t;

  localparam hazard_entry_t BUBBLE = '0;

  // True when a tracked instruction will write a non-x0 register equal to addr.
  function automatic logic writes_reg(input logic valid, input logic reg_write,
                                      input reg_addr_t rd, input reg_addr_t addr);
    return valid && reg_write && (rd != '0) && (rd == addr);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding mux select: youngest matching producer wins, x0 never forwards.
module fwd_select
  import riscv_defs::*;
(
  input  hazard_entry_t ex_mem_i,
  input  hazard_entry_t mem_wb_i,
  input  reg_addr_t     src_i,
  output forward_sel_t  sel_o
);

  always_comb begin
    sel_o = FWD_REGFILE;
    if (writes_reg(ex_mem_i.valid, ex_mem_i.reg_write, ex_mem_i.rd, src_i)) begin
      sel_o = FWD_EX_MEM;
    end else if (writes_reg(mem_wb_i.valid, mem_wb_i.reg_write, mem_wb_i.rd, src_i)) begin
      sel_o = FWD_WB;
    end
  end

  logic unused_fields;
  assign unused_fields = ^{ex_mem_i.rs1, ex_mem_i.rs2, ex_mem_i.mem_read,
                           mem_wb_i.rs1, mem_wb_i.rs2, mem_wb_i.mem_read};

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard tracker: EX operand forwarding, load-use stall and stall counter.
// HAZARD_FORWARDING_EN selects forwarding; undefined gives a stall-only interlock.
module hazard_forward_unit
  import riscv_defs::*;
#(
  parameter int unsigned NB_WORD = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_id_valid,
  input  logic [NB_REG_ADDR-1:0] i_id_rs1,
  input  logic [NB_REG_ADDR-1:0] i_id_rs2,
  input  logic [NB_REG_ADDR-1:0] i_id_rd,
  input  logic                   i_id_reg_write,
  input  logic                   i_id_mem_read,
  input  logic                   i_flush,
  output logic [1:0]             o_forward_rs1,
  output logic [1:0]             o_forward_rs2,
  output logic                   o_stall,
  output logic [NB_WORD-1:0]     o_stall_count
);

  hazard_entry_t id_entry;
  hazard_entry_t id_ex_d, id_ex_q;
  hazard_entry_t ex_mem_q, mem_wb_q;
  logic [NB_WORD-1:0] stall_count_d, stall_count_q;
  logic hazard;

  assign id_entry = '{valid:     i_id_valid,
                      rs1:       i_id_rs1,
                      rs2:       i_id_rs2,
                      rd:        i_id_rd,
                      reg_write: i_id_reg_write,
                      mem_read:  i_id_mem_read};

`ifdef HAZARD_FORWARDING_EN
  forward_sel_t sel_rs1, sel_rs2;

  fwd_select u_fwd_rs1 (
    .ex_mem_i (ex_mem_q),
    .mem_wb_i (mem_wb_q),
    .src_i    (id_ex_q.rs1),
    .sel_o    (sel_rs1)
  );

  fwd_select u_fwd_rs2 (
    .ex_mem_i (ex_mem_q),
    .mem_wb_i (mem_wb_q),
    .src_i    (id_ex_q.rs2),
    .sel_o    (sel_rs2)
  );

  assign o_forward_rs1 = sel_rs1;
  assign o_forward_rs2 = sel_rs2;

  // Only a load in EX cannot be covered by forwarding.
  assign hazard = i_id_valid && id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != '0) &&
                  ((id_ex_q.rd == i_id_rs1) || (id_ex_q.rd == i_id_rs2));
`else
  assign o_forward_rs1 = FWD_REGFILE;
  assign o_forward_rs2 = FWD_REGFILE;

  // Regfile writes in the first half-cycle, so an MEM/WB producer is already visible.
  assign hazard = i_id_valid &&
                  (writes_reg(id_ex_q.valid, id_ex_q.reg_write, id_ex_q.rd, i_id_rs1)   ||
                   writes_reg(id_ex_q.valid, id_ex_q.reg_write, id_ex_q.rd, i_id_rs2)   ||
                   writes_reg(ex_mem_q.valid, ex_mem_q.reg_write, ex_mem_q.rd, i_id_rs1) ||
                   writes_reg(ex_mem_q.valid, ex_mem_q.reg_write, ex_mem_q.rd, i_id_rs2));
`endif

  // A flush kills the ID instruction, so there is nothing left to stall for.
  assign o_stall = hazard && !i_flush;

  always_comb begin
    id_ex_d = BUBBLE;
    if (i_id_valid && !o_stall && !i_flush) begin
      id_ex_d = id_entry;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (o_stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + NB_WORD'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      id_ex_q       <= BUBBLE;
      ex_mem_q      <= BUBBLE;
      mem_wb_q      <= BUBBLE;
      stall_count_q <= '0;
    end else begin
      id_ex_q       <= id_ex_d;
      ex_mem_q      <= id_ex_q;
      mem_wb_q      <= ex_mem_q;
      stall_count_q <= stall_count_d;
    end
  end

  assign o_stall_count = stall_count_q;

  logic unused_fields;
  assign unused_fields = ^{id_ex_q, ex_mem_q, mem_wb_q};

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit; expectations follow HAZARD_FORWARDING_EN.
module tb_hazard_forward_unit;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_id_valid = 1'b0;
  logic [4:0] i_id_rs1 = '0;
  logic [4:0] i_id_rs2 = '0;
  logic [4:0] i_id_rd = '0;
  logic       i_id_reg_write = 1'b0;
  logic       i_id_mem_read = 1'b0;
  logic       i_flush = 1'b0;
  logic [1:0] o_forward_rs1;
  logic [1:0] o_forward_rs2;
  logic       o_stall;
  logic [2:0] o_stall_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_count = 0;

  always #5 i_clock = ~i_clock;

  hazard_forward_unit #(.NB_WORD(3)) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_id_valid     (i_id_valid),
    .i_id_rs1       (i_id_rs1),
    .i_id_rs2       (i_id_rs2),
    .i_id_rd        (i_id_rd),
    .i_id_reg_write (i_id_reg_write),
    .i_id_mem_read  (i_id_mem_read),
    .i_flush        (i_flush),
    .o_forward_rs1  (o_forward_rs1),
    .o_forward_rs2  (o_forward_rs2),
    .o_stall        (o_stall),
    .o_stall_count  (o_stall_count)
  );

  function automatic logic [2:0] sat_count(input int c);
    return (c > 7) ? 3'd7 : 3'(c);
  endfunction

  // Present one ID slot at the falling edge; outputs are stable 1 time unit later.
  task automatic drive(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input bit rw, input bit mr, input bit fl);
    @(negedge i_clock);
    i_id_valid = v; i_id_rs1 = rs1; i_id_rs2 = rs2; i_id_rd = rd;
    i_id_reg_write = rw; i_id_mem_read = mr; i_flush = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (4) idle();
  endtask

  // Hold an instruction in ID until accepted, returning how many cycles it stalled.
  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input bit rw, input bit mr, output int stalls);
    stalls = 0;
    drive(1'b1, rs1, rs2, rd, rw, mr, 1'b0);
    while (o_stall !== 1'b0 && stalls < 6) begin
      stalls++;
      drive(1'b1, rs1, rs2, rd, rw, mr, 1'b0);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (o_forward_rs1 !== 2'b00) begin
      n_err++; $display("FAIL reset_fwd_rs1: got %b want 00", o_forward_rs1);
    end
    n_vec++;
    if (o_forward_rs2 !== 2'b00) begin
      n_err++; $display("FAIL reset_fwd_rs2: got %b want 00", o_forward_rs2);
    end
    n_vec++;
    if (o_stall !== 1'b0) begin
      n_err++; $display("FAIL reset_stall: got %b want 0", o_stall);
    end
    n_vec++;
    if (o_stall_count !== 3'd0) begin
      n_err++; $display("FAIL reset_count: got %0d want 0", o_stall_count);
    end
    @(negedge i_clock);
    i_id_valid = 1'b0;
    i_reset = 1'b1;
    exp_count = 0;
  endtask

  task automatic test_ex_mem_forward();
    int s;
    logic [1:0] exp_fwd;
    drain();
    issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, s);
    n_vec++;
    if (s != 0) begin
      n_err++; $display("FAIL exmem_first_stalls: got %0d want 0", s);
    end
    issue(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, s);
    exp_count += FWD ? 0 : 2;
    n_vec++;
    if (s != (FWD ? 0 : 2)) begin
      n_err++; $display("FAIL exmem_dep_stalls: got %0d want %0d", s, FWD ? 0 : 2);
    end
    idle();
    exp_fwd = FWD ? 2'b10 : 2'b00;
    n_vec++;
    if (o_forward_rs1 !== exp_fwd) begin
      n_err++; $display("FAIL exmem_fwd_rs1: got %b want %b", o_forward_rs1, exp_fwd);
    end
    n_vec++;
    if (o_forward_rs2 !== 2'b00) begin
      n_err++; $display("FAIL exmem_fwd_rs2: got %b want 00", o_forward_rs2);
    end
    n_vec++;
    if (o_stall !== 1'b0) begin
      n_err++; $display("FAIL exmem_stall: got %b want 0", o_stall);
    end
  endtask

  task automatic test_wb_forward();
    int s;
    logic [1:0] exp_fwd;
    drain();
    issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, s);
    issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, s);
    n_vec++;
    if (s != 0) begin
      n_err++; $display("FAIL wb_nop_stalls: got %0d want 0", s);
    end
    issue(5'd1, 5'd5, 5'd7, 1'b1, 1'b0, s);
    exp_count += FWD ? 0 : 1;
    n_vec++;
    if (s != (FWD ? 0 : 1)) begin
      n_err++; $display("FAIL wb_sub_stalls: got %0d want %0d", s, FWD ? 0 : 1);
    end
    idle();
    exp_fwd = FWD ? 2'b01 : 2'b00;
    n_vec++;
    if (o_forward_rs2 !== exp_fwd) begin
      n_err++; $display("FAIL wb_fwd_rs2: got %b want %b", o_forward_rs2, exp_fwd);
    end
    n_vec++;
    if (o_forward_rs1 !== 2'b00) begin
      n_err++; $display("FAIL wb_fwd_rs1: got %b want 00", o_forward_rs1);
    end
  endtask

  task automatic test_load_use();
    int s;
    logic [1:0] exp_fwd;
    drain();
    issue(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, s);
    issue(5'd5, 5'd5, 5'd6, 1'b1, 1'b0, s);
    exp_count += FWD ? 1 : 2;
    n_vec++;
    if (s != (FWD ? 1 : 2)) begin
      n_err++; $display("FAIL lu_stalls: got %0d want %0d", s, FWD ? 1 : 2);
    end
    idle();
    exp_fwd = FWD ? 2'b01 : 2'b00;
    n_vec++;
    if (o_forward_rs1 !== exp_fwd) begin
      n_err++; $display("FAIL lu_fwd_rs1: got %b want %b", o_forward_rs1, exp_fwd);
    end
    n_vec++;
    if (o_forward_rs2 !== exp_fwd) begin
      n_err++; $display("FAIL lu_fwd_rs2: got %b want %b", o_forward_rs2, exp_fwd);
    end
    n_vec++;
    if (o_stall_count !== sat_count(exp_count)) begin
      n_err++;
      $display("FAIL lu_count: got %0d want %0d", o_stall_count, sat_count(exp_count));
    end
  endtask

  task automatic test_x0();
    int s;
    drain();
    issue(5'd1, 5'd0, 5'd0, 1'b1, 1'b1, s);
    issue(5'd0, 5'd0, 5'd6, 1'b1, 1'b0, s);
    n_vec++;
    if (s != 0) begin
      n_err++; $display("FAIL x0_stalls: got %0d want 0", s);
    end
    idle();
    n_vec++;
    if (o_forward_rs1 !== 2'b00) begin
      n_err++; $display("FAIL x0_fwd_rs1: got %b want 00", o_forward_rs1);
    end
    n_vec++;
    if (o_forward_rs2 !== 2'b00) begin
      n_err++; $display("FAIL x0_fwd_rs2: got %b want 00", o_forward_rs2);
    end
    idle();
    n_vec++;
    if (o_forward_rs1 !== 2'b00) begin
      n_err++; $display("FAIL x0_wb_fwd_rs1: got %b want 00", o_forward_rs1);
    end
  endtask

  task automatic test_flush();
    int s;
    drain();
    issue(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, s);
    drive(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b1);
    n_vec++;
    if (o_stall !== 1'b0) begin
      n_err++; $display("FAIL flush_stall: got %b want 0", o_stall);
    end
    idle();
    n_vec++;
    if (o_forward_rs1 !== 2'b00) begin
      n_err++; $display("FAIL flush_bubble_rs1: got %b want 00", o_forward_rs1);
    end
    n_vec++;
    if (o_stall !== 1'b0) begin
      n_err++; $display("FAIL flush_next_stall: got %b want 0", o_stall);
    end
    n_vec++;
    if (o_stall_count !== sat_count(exp_count)) begin
      n_err++;
      $display("FAIL flush_count: got %0d want %0d", o_stall_count, sat_count(exp_count));
    end
  endtask

  task automatic test_reset_mid_stall();
    int s;
    drain();
    issue(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, s);
    drive(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (o_stall !== 1'b1) begin
      n_err++; $display("FAIL rst_pre_stall: got %b want 1", o_stall);
    end
    #1 i_reset = 1'b0;
    #1;
    exp_count = 0;
    n_vec++;
    if (o_stall !== 1'b0) begin
      n_err++; $display("FAIL rst_stall_drop: got %b want 0", o_stall);
    end
    n_vec++;
    if (o_stall_count !== 3'd0) begin
      n_err++; $display("FAIL rst_count: got %0d want 0", o_stall_count);
    end
    @(negedge i_clock);
    i_id_valid = 1'b0;
    i_reset = 1'b1;
    issue(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, s);
    n_vec++;
    if (s != 0) begin
      n_err++; $display("FAIL rst_post_stalls: got %0d want 0", s);
    end
    idle();
    n_vec++;
    if (o_forward_rs1 !== 2'b00 || o_forward_rs2 !== 2'b00) begin
      n_err++;
      $display("FAIL rst_post_fwd: got %b/%b want 00/00", o_forward_rs1, o_forward_rs2);
    end
  endtask

  task automatic test_saturation();
    int s;
    drain();
    for (int k = 0; k < 8; k++) begin
      issue(5'd1, 5'd0, 5'd5, 1'b1, 1'b1, s);
      issue(5'd5, 5'd5, 5'd6, 1'b1, 1'b0, s);
      exp_count += FWD ? 1 : 2;
      n_vec++;
      if (s != (FWD ? 1 : 2)) begin
        n_err++; $display("FAIL sat_stalls[%0d]: got %0d want %0d", k, s, FWD ? 1 : 2);
      end
      idle();
      n_vec++;
      if (o_stall_count !== sat_count(exp_count)) begin
        n_err++;
        $display("FAIL sat_count[%0d]: got %0d want %0d", k, o_stall_count,
                 sat_count(exp_count));
      end
    end
  endtask

  initial begin
    test_reset();
    test_ex_mem_forward();
    test_wb_forward();
    test_load_use();
    test_x0();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary, %0d vectors so far", n_vec);
    $fatal(1);
  end

endmodule
